// File: rtl/ifetcher_pkg.sv
// ---------------------------------------------------------------------------
// ifetcher_pkg
// Shared definitions for the instruction-fetch PC generator:
//   state_t      - PC generator control states (BOOT, RUN, HALT)
//   DEF_STEP     - default sequential PC increment in bytes
//   DEF_EPW      - default redirect epoch counter width
//   alignBits()  - number of low PC bits that must be zero for a given STEP
// ---------------------------------------------------------------------------
package ifetcher_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int DEF_STEP = 4;
  localparam int DEF_EPW  = 2;

  // STEP is either 2 or 4 bytes; a legal PC has log2(STEP) low bits clear.
  function automatic int alignBits(input int step);
    return (step == 2) ? 1 : 2;
  endfunction

endpackage

// File: rtl/ifetcher_pcRedirArb.sv
// ---------------------------------------------------------------------------
// ifetcher_pcRedirArb
// Combinational redirect arbiter: picks trap over jump and forces the chosen
// target onto an instruction boundary.
// Ports:
//   iTrapVld / iTrapPC   - trap redirect request and target (wins)
//   iJumpVld / iJumpPC   - jump/branch redirect request and target
//   oRedirVld            - some redirect is requested this cycle
//   oRedirPC             - selected target with alignment bits cleared
//   oMisalign            - selected target had alignment bits set
// ---------------------------------------------------------------------------
module ifetcher_pcRedirArb
  import ifetcher_pkg::*;
#(
  parameter int PCW  = 32,
  parameter int STEP = DEF_STEP
) (
  input  logic           iTrapVld,
  input  logic [PCW-1:0] iTrapPC,
  input  logic           iJumpVld,
  input  logic [PCW-1:0] iJumpPC,
  output logic           oRedirVld,
  output logic [PCW-1:0] oRedirPC,
  output logic           oMisalign
);

  localparam int AB = alignBits(STEP);

  logic [PCW-1:0] rawPC;

  always_comb begin
    rawPC     = iTrapVld ? iTrapPC : iJumpPC;
    oRedirVld = iTrapVld | iJumpVld;
    oRedirPC  = {rawPC[PCW-1:AB], {AB{1'b0}}};
    oMisalign = oRedirVld & (|rawPC[AB-1:0]);
  end

endmodule

// File: rtl/ifetcher_pcgen.sv
// ---------------------------------------------------------------------------
// ifetcher_pcgen
// Fetch PC generator. Issues a PC with a valid/ready handshake, advances by
// STEP on acceptance, applies trap/jump redirects (bumping an epoch tag so
// in-flight fetches can be discarded) and can be suspended by iHalt.
// Ports:
//   iClk, iResetn         - clock (rising edge), async active-low reset
//   iTrapVld, iTrapPC     - trap redirect (highest priority)
//   iJumpVld, iJumpPC     - jump/branch redirect
//   iHalt                 - level; suspends issue while high
//   iPCRdy                - downstream accepts oPC
//   oPCVld, oPC           - fetch PC and its valid
//   oEpoch                - redirect epoch
//   oMisalign             - one-cycle pulse: redirect target was misaligned
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module ifetcher_pcgen
  import ifetcher_pkg::*;
#(
  parameter int             PCW      = 32,
  parameter logic [PCW-1:0] RESET_PC = '0,
  parameter int             STEP     = DEF_STEP,
  parameter int             EPW      = DEF_EPW
) (
  input  logic           iClk,
  input  logic           iResetn,
  input  logic           iTrapVld,
  input  logic [PCW-1:0] iTrapPC,
  input  logic           iJumpVld,
  input  logic [PCW-1:0] iJumpPC,
  input  logic           iHalt,
  input  logic           iPCRdy,
  output logic           oPCVld,
  output logic [PCW-1:0] oPC,
  output logic [EPW-1:0] oEpoch,
  output logic           oMisalign
);

  localparam logic [PCW-1:0] STEP_PC = PCW'(STEP);

  state_t         stateReg, stateNext;
  logic [PCW-1:0] pcReg, pcNext;
  logic           vldReg, vldNext;
  logic [EPW-1:0] epochReg, epochNext;
  logic           misalignReg, misalignNext;

  logic           redirVld;
  logic [PCW-1:0] redirPC;
  logic           redirMisalign;
  logic           handshake;

  ifetcher_pcRedirArb #(
    .PCW  (PCW),
    .STEP (STEP)
  ) uArb (
    .iTrapVld  (iTrapVld),
    .iTrapPC   (iTrapPC),
    .iJumpVld  (iJumpVld),
    .iJumpPC   (iJumpPC),
    .oRedirVld (redirVld),
    .oRedirPC  (redirPC),
    .oMisalign (redirMisalign)
  );

  // State and output registers
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      stateReg    <= BOOT;
      pcReg       <= RESET_PC;
      vldReg      <= 1'b0;
      epochReg    <= '0;
      misalignReg <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      pcReg       <= pcNext;
      vldReg      <= vldNext;
      epochReg    <= epochNext;
      misalignReg <= misalignNext;
    end
  end

  // Next-state logic: iHalt alone decides between RUN and HALT; BOOT only
  // lasts the first cycle after reset release.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      BOOT:    stateNext = iHalt ? HALT : RUN;
      RUN:     stateNext = iHalt ? HALT : RUN;
      HALT:    stateNext = iHalt ? HALT : RUN;
      default: stateNext = BOOT;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    // vldReg is 0 outside RUN, so iPCRdy is naturally ignored there.
    handshake = vldReg & iPCRdy;

    // A redirect wins over a same-cycle acceptance: the accepted PC is
    // replaced by the target rather than incremented.
    if (redirVld) begin
      pcNext = redirPC;
    end else if (handshake) begin
      pcNext = pcReg + STEP_PC;
    end else begin
      pcNext = pcReg;
    end

    vldNext      = (stateNext == RUN);
    epochNext    = epochReg + EPW'(redirVld);
    misalignNext = redirMisalign;
  end

  assign oPCVld    = vldReg;
  assign oPC       = pcReg;
  assign oEpoch    = epochReg;
  assign oMisalign = misalignReg;

endmodule

// File: tb/tb_ifetcher_pcgen.sv
// ---------------------------------------------------------------------------
// tb_ifetcher_pcgen
// Directed bench for ifetcher_pcgen. Accepted PCs (oPCVld & iPCRdy) are
// checked by a negedge monitor against an expected queue filled by the
// stimulus; halt/misalign/reset behaviour is checked directly. A second
// instance with PCW=8 covers PC and epoch wrap-around.
// ---------------------------------------------------------------------------
module tb_ifetcher_pcgen;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  ep;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // 32-bit DUT
  logic        iClk;
  logic        iResetn;
  logic        iTrapVld;
  logic [31:0] iTrapPC;
  logic        iJumpVld;
  logic [31:0] iJumpPC;
  logic        iHalt;
  logic        iPCRdy;
  logic        oPCVld;
  logic [31:0] oPC;
  logic [1:0]  oEpoch;
  logic        oMisalign;

  // 8-bit DUT
  logic       resetn8;
  logic       trap8;
  logic [7:0] trapPC8;
  logic       jv8;
  logic [7:0] jpc8;
  logic       halt8;
  logic       rdy8;
  logic       vld8;
  logic [7:0] pc8;
  logic [1:0] ep8;
  logic       mis8;

  ifetcher_pcgen uDut (
    .iClk      (iClk),
    .iResetn   (iResetn),
    .iTrapVld  (iTrapVld),
    .iTrapPC   (iTrapPC),
    .iJumpVld  (iJumpVld),
    .iJumpPC   (iJumpPC),
    .iHalt     (iHalt),
    .iPCRdy    (iPCRdy),
    .oPCVld    (oPCVld),
    .oPC       (oPC),
    .oEpoch    (oEpoch),
    .oMisalign (oMisalign)
  );

  ifetcher_pcgen #(
    .PCW      (8),
    .RESET_PC (8'hF8),
    .STEP     (4),
    .EPW      (2)
  ) uDut8 (
    .iClk      (iClk),
    .iResetn   (resetn8),
    .iTrapVld  (trap8),
    .iTrapPC   (trapPC8),
    .iJumpVld  (jv8),
    .iJumpPC   (jpc8),
    .iHalt     (halt8),
    .iPCRdy    (rdy8),
    .oPCVld    (vld8),
    .oPC       (pc8),
    .oEpoch    (ep8),
    .oMisalign (mis8)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic [1:0] ep);
    exp_t e;
    e.pc = pc;
    e.ep = ep;
    expQ.push_back(e);
  endtask

  // Scoreboard monitor: every accepted PC must match the next expectation.
  always @(negedge iClk) begin : mon
    exp_t e;
    if (oPCVld && iPCRdy) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL hs_unexpected: got pc 0x%0h want no handshake", oPC);
      end else begin
        e = expQ.pop_front();
        $display("accept pc=0x%0h epoch=%0d (expect pc=0x%0h epoch=%0d)", oPC, oEpoch, e.pc, e.ep);
        chk("hs_pc", oPC, e.pc);
        chk("hs_epoch", 32'(oEpoch), 32'(e.ep));
      end
    end
  end

  initial begin
    iResetn = 1'b0; iTrapVld = 1'b0; iTrapPC = '0; iJumpVld = 1'b0; iJumpPC = '0;
    iHalt = 1'b0; iPCRdy = 1'b0;
    resetn8 = 1'b0; trap8 = 1'b0; trapPC8 = '0; jv8 = 1'b0; jpc8 = '0;
    halt8 = 1'b0; rdy8 = 1'b0;

    // Reset state
    #3;
    chk("rst_vld", 32'(oPCVld), 32'd0);
    chk("rst_pc", oPC, 32'h0);
    chk("rst_epoch", 32'(oEpoch), 32'd0);
    chk("rst_misalign", 32'(oMisalign), 32'd0);
    step();
    step();
    chk("rst_hold_vld", 32'(oPCVld), 32'd0);

    // Sequential issue from reset with continuous ready
    pushExp(32'h0, 2'd0);
    pushExp(32'h4, 2'd0);
    iPCRdy = 1'b1;
    iResetn = 1'b1;
    step();                               // pc 0x0
    chk("boot_vld", 32'(oPCVld), 32'd1);
    chk("boot_pc", oPC, 32'h0);
    step();                               // pc 0x4
    step();                               // pc 0x8
    iPCRdy = 1'b0;
    chk("seq_pc8", oPC, 32'h8);

    // Backpressure: hold 0x8
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", oPC, 32'h8);
      chk("stall_vld", 32'(oPCVld), 32'd1);
    end
    pushExp(32'h8, 2'd0);
    pushExp(32'hC, 2'd0);
    iPCRdy = 1'b1;
    step();                               // pc 0xC, accepted this cycle

    // Trap and jump together with a handshake: trap wins, no increment
    iTrapVld = 1'b1; iTrapPC = 32'h100;
    iJumpVld = 1'b1; iJumpPC = 32'h200;
    step();
    iTrapVld = 1'b0; iJumpVld = 1'b0;
    pushExp(32'h100, 2'd1);
    chk("trap_misalign", 32'(oMisalign), 32'd0);
    step();                               // pc 0x104
    iPCRdy = 1'b0;
    chk("after_trap_pc", oPC, 32'h104);

    // Misaligned jump
    iJumpVld = 1'b1; iJumpPC = 32'h203;
    step();
    iJumpVld = 1'b0;
    chk("mis_pc", oPC, 32'h200);
    chk("mis_epoch", 32'(oEpoch), 32'd2);
    chk("mis_pulse", 32'(oMisalign), 32'd1);
    step();
    chk("mis_pulse_end", 32'(oMisalign), 32'd0);
    chk("mis_pc_hold", oPC, 32'h200);

    // Halt, redirect while halted, release
    iHalt = 1'b1;
    step();
    chk("halt_vld", 32'(oPCVld), 32'd0);
    chk("halt_pc_kept", oPC, 32'h200);
    iJumpVld = 1'b1; iJumpPC = 32'h400;
    step();
    iJumpVld = 1'b0;
    chk("halt_redir_vld", 32'(oPCVld), 32'd0);
    chk("halt_redir_pc", oPC, 32'h400);
    chk("halt_redir_epoch", 32'(oEpoch), 32'd3);
    step();
    chk("halt_still_vld", 32'(oPCVld), 32'd0);
    iHalt = 1'b0;
    iPCRdy = 1'b1;
    pushExp(32'h400, 2'd3);
    pushExp(32'h404, 2'd3);
    step();
    chk("release_vld", 32'(oPCVld), 32'd1);
    chk("release_pc", oPC, 32'h400);
    step();                               // pc 0x404, accepted this cycle

    // Halt and misaligned trap in the same cycle as a handshake
    iHalt = 1'b1;
    iTrapVld = 1'b1; iTrapPC = 32'h0FFF_FFF2;
    step();
    iTrapVld = 1'b0;
    iHalt = 1'b0;
    iPCRdy = 1'b0;
    chk("halt_trap_vld", 32'(oPCVld), 32'd0);
    chk("halt_trap_pc", oPC, 32'h0FFF_FFF0);
    chk("halt_trap_epoch_wrap", 32'(oEpoch), 32'd0);
    chk("halt_trap_mis", 32'(oMisalign), 32'd1);
    step();
    chk("resume_vld", 32'(oPCVld), 32'd1);
    chk("resume_pc", oPC, 32'h0FFF_FFF0);

    // Asynchronous reset mid-operation with a pending redirect
    iJumpVld = 1'b1; iJumpPC = 32'h800; iPCRdy = 1'b1;
    #2;
    iResetn = 1'b0;
    #1;
    chk("midrst_vld", 32'(oPCVld), 32'd0);
    chk("midrst_pc", oPC, 32'h0);
    chk("midrst_epoch", 32'(oEpoch), 32'd0);
    step();
    chk("midrst_hold_pc", oPC, 32'h0);
    iJumpVld = 1'b0; iPCRdy = 1'b0;

    // PCW=8: PC wrap and epoch wrap
    rdy8 = 1'b1;
    resetn8 = 1'b1;
    step();
    chk("p8_boot_pc", 32'(pc8), 32'hF8);
    step();
    chk("p8_pc_fc", 32'(pc8), 32'hFC);
    step();
    chk("p8_pc_wrap", 32'(pc8), 32'h00);
    rdy8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      jv8 = 1'b1;
      jpc8 = 8'((k + 1) * 16);
      step();
      chk("p8_redir_pc", 32'(pc8), 32'((k + 1) * 16));
      chk("p8_epoch", 32'(ep8), 32'((k + 1) % 4));
    end
    jv8 = 1'b0;
    step();

    chk("queue_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
